// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM state encoding and the
// {pc, instr} entry carried through the prefetch buffer.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StFull  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int unsigned EntryWidth = $bits(fetch_entry_t);
    localparam logic [3:0]  MemSelWord = 4'hF;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Prefetch buffer: DEPTH-entry circular FIFO of fetched {pc, instr} pairs.
// Head is read straight from registered storage; flush empties it in one cycle.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_flush,
    input  logic [EntryWidth-1:0] i_entry,
    output logic                  o_valid,
    output logic [EntryWidth-1:0] o_entry,
    output logic [CntW-1:0]       o_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign do_push = i_push && (count_q != CntW'(DEPTH));
    assign do_pop  = i_pop && (count_q != '0);

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= fetch_entry_t'(i_entry);
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    assign o_valid = (count_q != '0);
    assign o_entry = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues single-word TCM reads, buffers responses in a
// small prefetch FIFO and hands them to decode; redirects squash everything in flight.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned DEPTH        = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pc_set,
    input  logic [31:0] i_pc_target,
    output logic        o_mem_dev_sel,
    output logic [29:0] o_mem_addr,
    output logic [3:0]  o_mem_sel,
    output logic        o_mem_write,
    output logic [31:0] o_mem_data,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_data,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_ready
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic            outstanding_q, outstanding_d;

    logic [CntW-1:0] count;
    logic [CntW-1:0] count_next;
    logic [CntW-1:0] inflight;
    logic [CntW-1:0] inflight_next;
    logic            issue;
    logic            push;
    logic            pop;
    logic            fifo_valid;
    logic [EntryWidth-1:0] fifo_head;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            unused_tgt;

    assign unused_tgt = ^i_pc_target[1:0];

    // Buffer slots already spoken for; a same-cycle pop is deliberately not credited.
    assign inflight = count + CntW'(outstanding_q);
    assign issue    = (state_q == StFetch) && !i_pc_set && (inflight < CntW'(DEPTH));
    assign push     = i_mem_ack && outstanding_q && !i_pc_set;
    assign pop      = fifo_valid && i_ready;

    assign push_entry.pc    = req_pc_q;
    assign push_entry.instr = i_mem_data;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_pop   (pop),
        .i_flush (i_pc_set),
        .i_entry (push_entry),
        .o_valid (fifo_valid),
        .o_entry (fifo_head),
        .o_count (count)
    );

    assign head = fetch_entry_t'(fifo_head);

    always_comb begin
        count_next    = '0;
        outstanding_d = outstanding_q;
        req_pc_d      = req_pc_q;
        fetch_pc_d    = fetch_pc_q;

        if (!i_pc_set) begin
            count_next = count + CntW'(push) - CntW'(pop);
        end

        // Clearing on redirect makes the response to the squashed request look spurious.
        if (i_pc_set) begin
            outstanding_d = 1'b0;
        end else if (issue) begin
            outstanding_d = 1'b1;
        end else if (i_mem_ack) begin
            outstanding_d = 1'b0;
        end

        if (issue) begin
            req_pc_d = fetch_pc_q;
        end

        if (i_pc_set) begin
            fetch_pc_d = {i_pc_target[31:2], 2'b00};
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    assign inflight_next = count_next + CntW'(outstanding_d);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (!i_pc_set && (inflight_next == CntW'(DEPTH))) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (i_pc_set || (inflight_next < CntW'(DEPTH))) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= StIdle;
            fetch_pc_q    <= RESET_VECTOR;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Reset gating keeps outputs quiet from the very first reset cycle.
    assign o_mem_dev_sel = issue && !i_reset;
    assign o_mem_addr    = fetch_pc_q[31:2];
    assign o_mem_sel     = MemSelWord;
    assign o_mem_write   = 1'b0;
    assign o_mem_data    = '0;

    assign o_valid = fifo_valid && !i_reset;
    assign o_instr = i_reset ? 32'h0 : head.instr;
    assign o_pc    = i_reset ? 32'h0 : head.pc;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: first fetch address after reset, bits [1:0] zero.
REQ-002 Parameter DEPTH, default 2: prefetch buffer entries; power of two, >=2.
REQ-003 Port i_clk  input  1: single clock; all logic on rising edge.
REQ-004 Port i_reset  input  1: reset, synchronous, active-high.
REQ-005 Port i_pc_set  input  1: redirect strobe from execute (branch/jump/trap).
REQ-006 Port i_pc_target  input  32: redirect address; bits [1:0] ignored.
REQ-007 Port o_mem_dev_sel  output  1: fetch request to TCM, one word per asserted cycle.
REQ-008 Port o_mem_addr  output  30: word address, fetch_pc[31:2]; TCM consumes low bits.
REQ-009 Port o_mem_sel  output  4: constant 4'hF. Port o_mem_write  output  1: constant 0. Port o_mem_data  output  32: constant 0.
REQ-010 Port i_mem_ack  input  1: response valid, exactly one cycle after o_mem_dev_sel.
REQ-011 Port i_mem_data  input  32: instruction word, valid with i_mem_ack.
REQ-012 Port o_valid  output  1: o_instr/o_pc valid to decode.
REQ-013 Port o_instr  output  32; Port o_pc  output  32: head-of-buffer instruction and its address.
REQ-014 Port i_ready  input  1: decode accepts head when o_valid & i_ready.

Function
REQ-015 FSM states IDLE, FETCH, FULL; IDLE entered on reset, lasts exactly one cycle, then FETCH.
REQ-016 FETCH->FULL when buffer count + outstanding == DEPTH after this cycle's updates; FULL->FETCH when that sum < DEPTH; any state->FETCH on i_pc_set (except IDLE, which finishes its cycle normally).
REQ-017 o_mem_dev_sel SHALL be 1 only in FETCH, with i_pc_set low and (count + outstanding) < DEPTH; a pop in the same cycle is not credited.
REQ-018 Each issued request advances fetch_pc by 4; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-019 Outstanding flag set on issue, cleared on i_mem_ack; at most one outstanding.
REQ-020 On i_mem_ack with outstanding set and not squashed, push {pc_of_request, i_mem_data}; o_valid rises the following cycle.
REQ-021 i_mem_ack with outstanding clear SHALL be ignored.
REQ-022 i_pc_set in cycle N: buffer emptied at end of N, fetch_pc <= {i_pc_target[31:2],2'b00}, in-flight response arriving N+1 discarded, new request at N+1, o_valid no earlier than N+3.
REQ-023 i_pc_set coincident with o_valid & i_ready: redirect wins; popped entry counts as not consumed (decode also squashes).
REQ-024 Pop on o_valid & i_ready; simultaneous push and pop keeps count unchanged, order preserved.
REQ-025 o_valid SHALL be 0 whenever the buffer is empty; no combinational path from i_mem_* to o_*.

Reset
REQ-026 During i_reset: o_mem_dev_sel=0, o_valid=0, o_instr=0, o_pc=0, count=0, outstanding=0, fetch_pc=RESET_VECTOR, state=IDLE.
REQ-027 Response acknowledged in the first cycle after reset release SHALL be ignored (outstanding cleared by reset).
REQ-028 Reset asserted mid-burst overrides all other inputs in the same cycle.

Structure
REQ-029 Shared package holds the FSM state enum and fetch-entry struct {pc[31:0], instr[31:0]}.
REQ-030 One sub-module, fetch_fifo (DEPTH entries, registered output, count, push/pop/flush, sync reset).

Verification
REQ-031 Reset release, RESET_VECTOR=32'h100, i_ready=1 -> requests at 0x100,0x104,0x108 from cycle 1; o_valid from cycle 3, o_pc sequential.
REQ-032 i_ready=0 for 10 cycles -> exactly DEPTH responses buffered, o_mem_dev_sel low, state FULL; i_ready=1 -> drains in order, fetching resumes.
REQ-033 i_pc_set with target 32'h203 while response in flight -> stale response dropped, next o_pc=32'h200, o_valid at N+3.
REQ-034 fetch_pc=32'hFFFF_FFF8 -> o_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 i_reset pulsed with request outstanding -> all outputs zero, late ack ignored, restart from RESET_VECTOR.
REQ-036 Spurious i_mem_ack without request -> no push, o_valid unchanged.
